// File: rtl/adder_tree_sequencer_pkg.sv
// Shared types and default sizing for the adder tree sequencer and its lane accumulators.
package seq_pkg;

  localparam int LANES    = 256;
  localparam int SUM_W    = 17;
  localparam int ACC_W    = 24;
  localparam int TREE_LAT = 2;
  localparam int CNT_W    = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  // Widens one signed tree lane sum to accumulator width.
  function automatic logic [ACC_W-1:0] sign_extend(input logic [SUM_W-1:0] value);
    return {{(ACC_W - SUM_W){value[SUM_W-1]}}, value};
  endfunction

endpackage

// File: rtl/lane_accumulator.sv
// One signed lane accumulator: synchronous clear, add-enable, wraps modulo 2^W.
module lane_accumulator #(
  parameter int W = seq_pkg::ACC_W
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         add_en,
  input  logic [W-1:0] addend,
  output logic [W-1:0] acc
);

  always_ff @(posedge clock) begin
    if (reset) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (add_en) begin
      acc <= acc + addend;
    end
  end

endmodule

// File: rtl/adder_tree_sequencer.sv
// Feeds P product passes into the enable-gated adder tree and accumulates the
// retired lane sums into one result vector presented with a valid/ready handshake.
module adder_tree_sequencer
  import seq_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [CNT_W-1:0]       pass_count,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   tree_enable,
  input  logic [LANES*SUM_W-1:0] tree_sum,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*ACC_W-1:0] out_sum,
  output logic                   busy,
  output logic                   err_zero
);

  state_t              state;
  state_t              state_next;
  logic [CNT_W-1:0]    pass_total;
  logic [CNT_W-1:0]    issued;
  logic [CNT_W-1:0]    retired;
  logic [TREE_LAT-1:0] vld;
  logic                accept;
  logic                clear;
  logic                retire;

  assign busy   = (state != IDLE);
  assign retire = tree_enable & vld[TREE_LAT-1];

  // DRAIN finishes on the cycle the final retire happens, so DONE follows it directly.
  always_comb begin
    state_next  = state;
    in_ready    = 1'b0;
    tree_enable = 1'b0;
    out_valid   = 1'b0;
    accept      = 1'b0;
    clear       = 1'b0;
    case (state)
      IDLE: begin
        if (start && (pass_count != '0)) begin
          clear      = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        in_ready    = (issued < pass_total);
        accept      = in_valid & in_ready;
        tree_enable = accept;
        if (accept && ((issued + CNT_W'(1)) == pass_total)) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        tree_enable = 1'b1;
        if (vld[TREE_LAT-1] && ((retired + CNT_W'(1)) == pass_total)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      pass_total <= '0;
      issued     <= '0;
      retired    <= '0;
      vld        <= '0;
      err_zero   <= 1'b0;
    end else begin
      state    <= state_next;
      err_zero <= (state == IDLE) && start && (pass_count == '0);
      if (clear) begin
        pass_total <= pass_count;
        issued     <= '0;
        retired    <= '0;
        vld        <= '0;
      end else begin
        if (accept) begin
          issued <= issued + CNT_W'(1);
        end
        if (retire) begin
          retired <= retired + CNT_W'(1);
        end
        // vld mirrors the tree pipeline, so it only moves when the tree does.
        if (tree_enable) begin
          vld <= (vld << 1) | TREE_LAT'(accept);
        end
      end
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    lane_accumulator #(.W(ACC_W)) u_acc (
      .clock  (clock),
      .reset  (reset),
      .clear  (clear),
      .add_en (retire),
      .addend (sign_extend(tree_sum[i*SUM_W +: SUM_W])),
      .acc    (out_sum[i*ACC_W +: ACC_W])
    );
  end

endmodule

// File: tb/tb_adder_tree_sequencer.sv
// Directed bench for adder_tree_sequencer with a behavioural two-stage enable-gated tree.
module tb_adder_tree_sequencer;
  import seq_pkg::*;

  logic                   clock;
  logic                   reset;
  logic                   start;
  logic [CNT_W-1:0]       pass_count;
  logic                   in_valid;
  logic                   in_ready;
  logic                   tree_enable;
  logic [LANES*SUM_W-1:0] tree_sum;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*ACC_W-1:0] out_sum;
  logic                   busy;
  logic                   err_zero;

  logic [LANES*SUM_W-1:0] prod;
  logic [LANES*SUM_W-1:0] s1;
  logic [LANES*SUM_W-1:0] s2;

  int tests;
  int failures;
  int first_bad;

  adder_tree_sequencer dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .pass_count  (pass_count),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .tree_enable (tree_enable),
    .tree_sum    (tree_sum),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sum     (out_sum),
    .busy        (busy),
    .err_zero    (err_zero)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else if (tree_enable) begin
      s1 <= prod;
      s2 <= s1;
    end
  end
  assign tree_sum = s2;

  function automatic int lane_val(input int mode, input int pass, input int lane);
    case (mode)
      0:       return 5;
      1:       return lane - 128;
      2:       return lane * (pass + 1) - 300;
      3:       return (lane == 0) ? 65535 : 0;
      default: return lane - 7 * pass;
    endcase
  endfunction

  function automatic logic [ACC_W-1:0] exp_lane(input int p, input int mode, input int lane);
    int s;
    s = 0;
    for (int k = 0; k < p; k++) s += lane_val(mode, k, lane);
    return ACC_W'(s);
  endfunction

  function automatic int bad_lanes(input int p, input int mode);
    int bad;
    bad = 0;
    first_bad = 0;
    for (int i = 0; i < LANES; i++) begin
      if (out_sum[i*ACC_W +: ACC_W] !== exp_lane(p, mode, i)) begin
        if (bad == 0) first_bad = i;
        bad++;
      end
    end
    return bad;
  endfunction

  task automatic set_prod(input int mode, input int pass);
    for (int i = 0; i < LANES; i++) prod[i*SUM_W +: SUM_W] = SUM_W'(lane_val(mode, pass, i));
  endtask

  task automatic set_poison();
    for (int i = 0; i < LANES; i++) prod[i*SUM_W +: SUM_W] = SUM_W'(1000);
  endtask

  // Cycle 0 carries start; returns the first cycle out_valid is seen, or -1.
  task automatic run_job(input int p, input int mode, input int gap, input int stop_cycle,
                         output int valid_cycle, output int gap_errs);
    int pass_idx;
    int gap_cnt;
    int limit;
    bit acc;
    pass_idx = 0;
    gap_cnt = 0;
    valid_cycle = -1;
    gap_errs = 0;
    limit = p * (gap + 1) + TREE_LAT + 20;
    @(negedge clock);
    start = 1'b1;
    pass_count = CNT_W'(p);
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(posedge clock);
    for (int c = 1; c <= limit; c++) begin
      @(negedge clock);
      start = 1'b0;
      if (stop_cycle == 0 && out_valid) begin
        valid_cycle = c;
        break;
      end
      if (pass_idx < p && gap_cnt == 0) begin
        in_valid = 1'b1;
        set_prod(mode, pass_idx);
      end else begin
        in_valid = 1'b0;
        set_poison();
      end
      #1;
      if (gap > 0 && !in_valid && pass_idx < p && tree_enable) gap_errs++;
      if (c == stop_cycle) break;
      acc = in_valid && in_ready;
      @(posedge clock);
      if (acc) begin
        pass_idx++;
        gap_cnt = gap;
      end else if (gap_cnt > 0) begin
        gap_cnt--;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    tests++;
    if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_in_ready got %b want 0", in_ready); end
    tests++;
    if (tree_enable !== 1'b0) begin failures++; $display("[TB] FAIL reset_tree_enable got %b want 0", tree_enable); end
    tests++;
    if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid got %b want 0", out_valid); end
    tests++;
    if (out_sum !== '0) begin failures++; $display("[TB] FAIL reset_out_sum lane0 got %0h want 0", out_sum[ACC_W-1:0]); end
    tests++;
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    tests++;
    if (err_zero !== 1'b0) begin failures++; $display("[TB] FAIL reset_err_zero got %b want 0", err_zero); end
  endtask

  task automatic test_single_pass();
    int vc, ge;
    run_job(1, 0, 0, 0, vc, ge);
    tests++;
    if (vc !== 4) begin failures++; $display("[TB] FAIL single_latency got cycle %0d want 4", vc); end
    tests++;
    if (bad_lanes(1, 0) !== 0) begin
      failures++;
      $display("[TB] FAIL single_sums lane %0d got %0h want %0h", first_bad,
               out_sum[first_bad*ACC_W +: ACC_W], exp_lane(1, 0, first_bad));
    end
    release_result();
    tests++;
    if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL single_valid_drop got %b want 0", out_valid); end
    tests++;
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL single_busy_after got %b want 0", busy); end
  endtask

  task automatic test_signed_lanes();
    int vc, ge;
    run_job(4, 1, 0, 0, vc, ge);
    tests++;
    if (vc !== 7) begin failures++; $display("[TB] FAIL signed_latency got cycle %0d want 7", vc); end
    tests++;
    if (out_sum[ACC_W-1:0] !== 24'hFFFE00) begin
      failures++;
      $display("[TB] FAIL signed_lane0 got %0h want fffe00", out_sum[ACC_W-1:0]);
    end
    tests++;
    if (bad_lanes(4, 1) !== 0) begin
      failures++;
      $display("[TB] FAIL signed_sums lane %0d got %0h want %0h", first_bad,
               out_sum[first_bad*ACC_W +: ACC_W], exp_lane(4, 1, first_bad));
    end
    release_result();
  endtask

  task automatic test_upstream_gaps();
    int vc, ge;
    run_job(3, 2, 1, 0, vc, ge);
    tests++;
    if (ge !== 0) begin failures++; $display("[TB] FAIL gap_tree_enable got %0d enabled gap cycles want 0", ge); end
    tests++;
    if (vc !== 8) begin failures++; $display("[TB] FAIL gap_latency got cycle %0d want 8", vc); end
    tests++;
    if (bad_lanes(3, 2) !== 0) begin
      failures++;
      $display("[TB] FAIL gap_sums lane %0d got %0h want %0h", first_bad,
               out_sum[first_bad*ACC_W +: ACC_W], exp_lane(3, 2, first_bad));
    end
    release_result();
  endtask

  task automatic test_wrap();
    int vc, ge;
    run_job(256, 3, 0, 0, vc, ge);
    tests++;
    if (vc !== 259) begin failures++; $display("[TB] FAIL wrap_latency got cycle %0d want 259", vc); end
    tests++;
    if (out_sum[ACC_W-1:0] !== 24'hFFFF00) begin
      failures++;
      $display("[TB] FAIL wrap_lane0 got %0h want ffff00", out_sum[ACC_W-1:0]);
    end
    tests++;
    if (bad_lanes(256, 3) !== 0) begin
      failures++;
      $display("[TB] FAIL wrap_sums lane %0d got %0h want %0h", first_bad,
               out_sum[first_bad*ACC_W +: ACC_W], exp_lane(256, 3, first_bad));
    end
    release_result();
  endtask

  task automatic test_backpressure();
    int vc, ge;
    run_job(2, 4, 0, 0, vc, ge);
    tests++;
    if (vc !== 5) begin failures++; $display("[TB] FAIL bp_latency got cycle %0d want 5", vc); end
    for (int h = 0; h < 10; h++) begin
      tests++;
      if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL bp_hold_valid cycle %0d got %b want 1", h, out_valid); end
      tests++;
      if (bad_lanes(2, 4) !== 0) begin
        failures++;
        $display("[TB] FAIL bp_hold_sums cycle %0d lane %0d got %0h want %0h", h, first_bad,
                 out_sum[first_bad*ACC_W +: ACC_W], exp_lane(2, 4, first_bad));
      end
      start = (h == 3);
      pass_count = CNT_W'(5);
      @(negedge clock);
    end
    start = 1'b0;
    release_result();
    tests++;
    if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL bp_valid_drop got %b want 0", out_valid); end
    tests++;
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL bp_busy_after got %b want 0", busy); end
    @(negedge clock);
    tests++;
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL bp_start_ignored busy got %b want 0", busy); end
  endtask

  task automatic test_err_zero();
    @(negedge clock);
    start = 1'b1;
    pass_count = '0;
    @(negedge clock);
    start = 1'b0;
    tests++;
    if (err_zero !== 1'b1) begin failures++; $display("[TB] FAIL err_zero_pulse got %b want 1", err_zero); end
    tests++;
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL err_zero_busy got %b want 0", busy); end
    @(negedge clock);
    tests++;
    if (err_zero !== 1'b0) begin failures++; $display("[TB] FAIL err_zero_width got %b want 0", err_zero); end
  endtask

  task automatic test_reset_in_drain();
    int vc, ge;
    run_job(2, 4, 0, 3, vc, ge);
    tests++;
    if ({in_ready, tree_enable, busy} !== 3'b011) begin
      failures++;
      $display("[TB] FAIL drain_state got ready/en/busy %b want 011", {in_ready, tree_enable, busy});
    end
    reset = 1'b1;
    @(negedge clock);
    tests++;
    if ({in_ready, tree_enable, out_valid, busy, err_zero} !== 5'b0) begin
      failures++;
      $display("[TB] FAIL drain_reset_ctrl got %b want 00000", {in_ready, tree_enable, out_valid, busy, err_zero});
    end
    tests++;
    if (out_sum !== '0) begin failures++; $display("[TB] FAIL drain_reset_sum lane0 got %0h want 0", out_sum[ACC_W-1:0]); end
    reset = 1'b0;
    run_job(2, 4, 0, 0, vc, ge);
    tests++;
    if (vc !== 5) begin failures++; $display("[TB] FAIL post_reset_latency got cycle %0d want 5", vc); end
    tests++;
    if (bad_lanes(2, 4) !== 0) begin
      failures++;
      $display("[TB] FAIL post_reset_sums lane %0d got %0h want %0h", first_bad,
               out_sum[first_bad*ACC_W +: ACC_W], exp_lane(2, 4, first_bad));
    end
    release_result();
  endtask

  initial begin
    tests = 0;
    failures = 0;
    clock = 1'b0;
    reset = 1'b1;
    start = 1'b0;
    pass_count = '0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    prod = '0;
    repeat (3) @(posedge clock);
    test_reset();
    test_single_pass();
    test_signed_lanes();
    test_upstream_gaps();
    test_wrap();
    test_backpressure();
    test_err_zero();
    test_reset_in_drain();
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
